// File: rtl/apx_rt_pkg.sv
// apx_rt_pkg: shared constants and tree-shape helpers for apx_rt_pipe.
package apx_rt_pkg;
  localparam int ERR_CNT_W = 16;
  localparam logic MODE_OR = 1'b0;
  localparam logic MODE_XS = 1'b1;
  function automatic int levels(input int n);
    int l = 1;
    for (int m = n / 2; m > 1; m = m / 4) l++;
    return l;
  endfunction
  function automatic int lvl_cnt(input int n, input int l);
    return n >> (2 * (l + 1));
  endfunction
  function automatic int lvl_off(input int n, input int l);
    int o = 0;
    for (int k = 0; k < l; k++) o += lvl_cnt(n, k);
    return o;
  endfunction
  function automatic int ncout(input int n);
    return lvl_off(n, levels(n) - 1);
  endfunction
  function automatic int ncmp(input int n);
    return ncout(n) + 1;
  endfunction
endpackage

// File: rtl/apx_rt_pipe_cprs42.sv
// apx_cprs42: combinational approximate 4:2 compressor, OR-approximate or XOR-saturating.
module apx_cprs42
  import apx_rt_pkg::*;
(
  input  logic [3:0] a,
  input  logic       mode,
  output logic       sum,
  output logic       carry,
  output logic       err
);
  logic p, q, r, s, x12, x34;
  always_comb begin
    p = a[0] | a[1];
    q = a[2] | a[3];
    r = a[0] & a[1];
    s = a[2] & a[3];
    x12 = a[0] ^ a[1];
    x34 = a[2] ^ a[3];
    err = mode == MODE_OR ? r & s : &a;
    sum = mode == MODE_OR ? (p ^ q) ^ (r | s) : (x12 ^ x34) | err;
    carry = mode == MODE_XS ? (x12 & x34) | (r ^ s) | err : ((p | q) & (r | s)) | (p & q);
  end
endmodule

// File: rtl/apx_rt_pipe.sv
// apx_rt_pipe: pipelined approximate 4:2 reduction-tree column with error tracking.
// Define APX_ERR_CNT_EN to include the saturating erroneous-transaction counter.
module apx_rt_pipe
  import apx_rt_pkg::*;
#(
  parameter int N_IN = 8,
  parameter int PIPE_LVL = 0,
  localparam int LEVELS = levels(N_IN),
  localparam int NCOUT = ncout(N_IN),
  localparam int NCMP = NCOUT + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [N_IN-1:0]      x,
  input  logic [1:0]           cin,
  input  logic                 mode,
  output logic                 out_valid,
  output logic                 sum_r,
  output logic                 carry_r,
  output logic [NCOUT-1:0]     cout_r,
  output logic [NCMP-1:0]      err_vec_r,
  output logic                 error_r,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_cnt_clr
);
  localparam int F = LEVELS - 1;
  logic st_v [LEVELS];
  logic st_m [LEVELS];
  logic [1:0] st_c [LEVELS];
  logic [N_IN-1:0] st_s [LEVELS];
  logic [NCOUT-1:0] st_co [LEVELS];
  logic [NCOUT-1:0] st_e [LEVELS];
  logic [NCMP-1:0] cs, cc, ce;
  assign st_v[0] = in_valid;
  assign st_m[0] = mode;
  assign st_c[0] = cin;
  assign st_s[0] = x;
  assign st_co[0] = '0;
  assign st_e[0] = '0;
  // Each non-final level folds its carries/errs into the accumulators that ride with the transaction
  for (genvar l = 0; l < F; l++) begin : g_lvl
    localparam int CNT = lvl_cnt(N_IN, l);
    localparam int OFF = lvl_off(N_IN, l);
    logic [N_IN-1:0] ls_d;
    logic [NCOUT-1:0] lco_d, le_d;
    for (genvar i = 0; i < CNT; i++) begin : g_c
      apx_cprs42 u_c (.a(st_s[l][4*i +: 4]), .mode(st_m[l]), .sum(cs[OFF+i]), .carry(cc[OFF+i]), .err(ce[OFF+i]));
    end
    always_comb begin
      ls_d = '0;
      ls_d[CNT-1:0] = cs[OFF +: CNT];
      lco_d = st_co[l];
      lco_d[OFF +: CNT] = cc[OFF +: CNT];
      le_d = st_e[l];
      le_d[OFF +: CNT] = ce[OFF +: CNT];
    end
    if (PIPE_LVL != 0) begin : g_reg
      logic pv_q, pm_q;
      logic [1:0] pc_q;
      logic [N_IN-1:0] ps_q;
      logic [NCOUT-1:0] pco_q, pe_q;
      always_ff @(posedge clk)
        if (!rst_n) begin
          pv_q <= 1'b0;
          pm_q <= 1'b0;
          pc_q <= '0;
          ps_q <= '0;
          pco_q <= '0;
          pe_q <= '0;
        end else begin
          pv_q <= st_v[l];
          if (st_v[l]) begin
            pm_q <= st_m[l];
            pc_q <= st_c[l];
            ps_q <= ls_d;
            pco_q <= lco_d;
            pe_q <= le_d;
          end
        end
      assign st_v[l+1] = pv_q;
      assign st_m[l+1] = pm_q;
      assign st_c[l+1] = pc_q;
      assign st_s[l+1] = ps_q;
      assign st_co[l+1] = pco_q;
      assign st_e[l+1] = pe_q;
    end else begin : g_wire
      assign st_v[l+1] = st_v[l];
      assign st_m[l+1] = st_m[l];
      assign st_c[l+1] = st_c[l];
      assign st_s[l+1] = ls_d;
      assign st_co[l+1] = lco_d;
      assign st_e[l+1] = le_d;
    end
  end
  apx_cprs42 u_f (.a({st_c[F], st_s[F][1:0]}), .mode(st_m[F]), .sum(cs[NCMP-1]), .carry(cc[NCMP-1]), .err(ce[NCMP-1]));
  logic v_q, sum_d, sum_q, carry_d, carry_q;
  logic [NCOUT-1:0] co_d, co_q;
  logic [NCMP-1:0] ev_d, ev_q;
  always_comb begin
    sum_d = st_v[F] ? cs[NCMP-1] : sum_q;
    carry_d = st_v[F] ? cc[NCMP-1] : carry_q;
    co_d = st_v[F] ? st_co[F] : co_q;
    ev_d = st_v[F] ? {ce[NCMP-1], st_e[F]} : ev_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      v_q <= 1'b0;
      sum_q <= 1'b0;
      carry_q <= 1'b0;
      co_q <= '0;
      ev_q <= '0;
    end else begin
      v_q <= st_v[F];
      sum_q <= sum_d;
      carry_q <= carry_d;
      co_q <= co_d;
      ev_q <= ev_d;
    end
  assign out_valid = v_q;
  assign sum_r = sum_q;
  assign carry_r = carry_q;
  assign cout_r = co_q;
  assign err_vec_r = ev_q;
  assign error_r = |ev_q;
`ifdef APX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
  always_comb err_cnt_d = err_cnt_clr ? '0 : (st_v[F] && |ev_d && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
  always_ff @(posedge clk) err_cnt_q <= !rst_n ? '0 : err_cnt_d;
  assign err_cnt = err_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = err_cnt_clr;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_apx_rt_pipe.sv
// tb_apx_rt_pipe: randomized check of apx_rt_pipe (8/comb and 32/pipelined) against a popcount tree model.
module tb_apx_rt_pipe;
  typedef struct packed {
    int due;
    logic s;
    logic c;
    logic [63:0] co;
    logic [63:0] ev;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0, clr = 1'b0;
  logic [7:0] x8 = '0;
  logic [31:0] x32 = '0;
  logic [1:0] c8 = '0, c32 = '0;
  logic m8 = 1'b0, m32 = 1'b0;
  logic o8_v, o8_s, o8_c, o8_e, o32_v, o32_s, o32_c, o32_e;
  logic [1:0] o8_co;
  logic [2:0] o8_ev;
  logic [9:0] o32_co;
  logic [10:0] o32_ev;
  logic [15:0] o8_cnt, o32_cnt, n8 = '0, n32 = '0;
  exp_t q8[$], q32[$];
  exp_t l8 = '0, l32 = '0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  apx_rt_pipe #(.N_IN(8), .PIPE_LVL(0)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .x(x8), .cin(c8), .mode(m8),
    .out_valid(o8_v), .sum_r(o8_s), .carry_r(o8_c), .cout_r(o8_co), .err_vec_r(o8_ev),
    .error_r(o8_e), .err_cnt(o8_cnt), .err_cnt_clr(clr));
  apx_rt_pipe #(.N_IN(32), .PIPE_LVL(1)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .x(x32), .cin(c32), .mode(m32),
    .out_valid(o32_v), .sum_r(o32_s), .carry_r(o32_c), .cout_r(o32_co), .err_vec_r(o32_ev),
    .error_r(o32_e), .err_cnt(o32_cnt), .err_cnt_clr(clr));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask
  // Both compressor modes reduce to: value = min(popcount, 3), error when all four inputs are set
  function automatic exp_t model(input int n, input logic [31:0] xv, input logic [1:0] ci);
    exp_t r;
    int cur[32];
    int cnt, k, pc, v;
    r = '0;
    cnt = n;
    k = 0;
    for (int i = 0; i < n; i++) cur[i] = int'(xv[i]);
    while (cnt > 2) begin
      for (int i = 0; i < cnt / 4; i++) begin
        pc = cur[4*i] + cur[4*i+1] + cur[4*i+2] + cur[4*i+3];
        v = pc > 3 ? 3 : pc;
        r.co[k] = v >= 2;
        r.ev[k] = pc == 4;
        cur[i] = v % 2;
        k++;
      end
      cnt = cnt / 4;
    end
    pc = cur[0] + cur[1] + int'(ci[0]) + int'(ci[1]);
    v = pc > 3 ? 3 : pc;
    r.s = v[0];
    r.c = v >= 2;
    r.ev[k] = pc == 4;
    return r;
  endfunction
  function automatic logic [15:0] cnt_next(input logic [15:0] c, input logic dl, input logic [63:0] ev);
`ifdef APX_ERR_CNT_EN
    if (clr) return '0;
    if (dl && ev != 0 && c != 16'hFFFF) return c + 16'd1;
    return c;
`else
    return '0;
`endif
  endfunction
  task automatic check_all();
    logic dl8, dl32;
    if (!rst_n) begin
      q8.delete();
      q32.delete();
      l8 = '0;
      l32 = '0;
      n8 = '0;
      n32 = '0;
    end
    dl8 = q8.size() > 0 && q8[0].due == cyc;
    dl32 = q32.size() > 0 && q32[0].due == cyc;
    if (dl8) l8 = q8.pop_front();
    if (dl32) l32 = q32.pop_front();
    if (rst_n) begin
      n8 = cnt_next(n8, dl8, l8.ev);
      n32 = cnt_next(n32, dl32, l32.ev);
    end
    chk("valid8", 64'(o8_v), 64'(dl8));
    chk("sum8", 64'(o8_s), 64'(l8.s));
    chk("carry8", 64'(o8_c), 64'(l8.c));
    chk("cout8", 64'(o8_co), l8.co);
    chk("errvec8", 64'(o8_ev), l8.ev);
    chk("error8", 64'(o8_e), 64'(l8.ev != 0));
    chk("errcnt8", 64'(o8_cnt), 64'(n8));
    chk("valid32", 64'(o32_v), 64'(dl32));
    chk("sum32", 64'(o32_s), 64'(l32.s));
    chk("carry32", 64'(o32_c), 64'(l32.c));
    chk("cout32", 64'(o32_co), l32.co);
    chk("errvec32", 64'(o32_ev), l32.ev);
    chk("error32", 64'(o32_e), 64'(l32.ev != 0));
    chk("errcnt32", 64'(o32_cnt), 64'(n32));
  endtask
  task automatic step(input logic r, input logic v, input logic cl, input logic [7:0] a8, input logic [1:0] ci8, input logic md8);
    exp_t e;
    @(negedge clk);
    check_all();
    rst_n = r;
    vld = v;
    clr = cl;
    x8 = a8;
    c8 = ci8;
    m8 = md8;
    x32 = $urandom;
    if ($urandom_range(0, 3) == 0) x32 = x32 | 32'hF0F0_000F;
    c32 = 2'($urandom);
    m32 = 1'($urandom);
    if (r && v) begin
      e = model(8, {24'b0, a8}, ci8);
      e.due = cyc + 1;
      q8.push_back(e);
      e = model(32, x32, c32);
      e.due = cyc + 3;
      q32.push_back(e);
    end
  endtask
  task automatic rnd(input logic v);
    step(1'b1, v, 1'b0, 8'($urandom), 2'($urandom), 1'($urandom));
  endtask
  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h01, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 2'b00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 2'b00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 2'b11, 1'b1);
    rnd(1'b0);
    rnd(1'b1);
    rnd(1'b1);
    rnd(1'b0);
    repeat (3) rnd(1'b1);
    repeat (4) rnd(1'b0);
    rnd(1'b1);
    rnd(1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0, 8'hFF, 2'b11, 1'b0);
    repeat (4) rnd(1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'hFF, 2'b00, 1'b0);
    rnd(1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 2'b00, 1'b0);
    repeat (4) rnd(1'b0);
`ifdef APX_ERR_CNT_EN
    force d8.err_cnt_q = 16'hFFFF;
    #1 release d8.err_cnt_q;
    n8 = 16'hFFFF;
`endif
    step(1'b1, 1'b1, 1'b0, 8'hFF, 2'b00, 1'b1);
    repeat (3) rnd(1'b0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
           8'($urandom), 2'($urandom), 1'($urandom));
    repeat (5) rnd(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
